// File: rtl/ram_arb_ctrl_if.sv
// Bundle of requester handshakes, status and RAM pins for ram_arb_ctrl.
// slave = the controller side, master = the requesters plus the RAM.
interface ram_arb_ctrl_if;
  localparam int unsigned AW = 3;
  localparam int unsigned DW = 8;

  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic          busy;
  logic          gnt_id;

  logic [DW-1:0] ram_inp;
  logic [AW-1:0] ram_addr;
  logic          ram_op;
  logic          ram_sel;
  logic [DW-1:0] ram_outp;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_outp,
    output ack0, rdata0, ack1, rdata1,
    output busy, gnt_id,
    output ram_inp, ram_addr, ram_op, ram_sel
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_outp,
    input  ack0, rdata0, ack1, rdata1,
    input  busy, gnt_id,
    input  ram_inp, ram_addr, ram_op, ram_sel
  );
endinterface

// File: rtl/ram_arb_ctrl.sv
// Two-port arbiter/sequencer for an 8x8 byte RAM: setup -> strobe -> recover.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority to port 0.
module ram_arb_ctrl #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arb_ctrl_if.slave bus
);
  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  state_t           r_state, w_state_nxt;
  cmd_t             r_cmd, w_cmd_nxt, w_win_cmd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sel, r_busy, r_gnt_id, r_ack0, r_ack1;
  logic [DW-1:0]    r_rdata0, r_rdata1;
  logic             w_sel_nxt, w_busy_nxt, w_gnt_nxt, w_ack0_nxt, w_ack1_nxt;
  logic [DW-1:0]    w_rdata0_nxt, w_rdata1_nxt;
  logic             w_any, w_win, w_grant, w_last;

  assign w_any   = bus.req0 | bus.req1;
  assign w_grant = (r_state == IDLE) && w_any;
  assign w_last  = (r_cnt == CNT_W'(STROBE_CYCLES - 1));

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic r_pref;

  // On a tie the preferred port wins; preference flips after every grant.
  assign w_win = bus.req0 ? (bus.req1 & r_pref) : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_pref <= 1'b0;
    else if (w_grant) r_pref <= ~w_win;
  end
`else
  assign w_win = ~bus.req0;
`endif

  assign w_win_cmd = w_win ? cmd_t'{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1}
                           : cmd_t'{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)  w_state_nxt = SETUP;
      SETUP:               w_state_nxt = STROBE;
      STROBE:  if (w_last) w_state_nxt = RECOVER;
      RECOVER:             w_state_nxt = IDLE;
      default:             w_state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of every registered output
  always_comb begin
    w_cmd_nxt    = r_cmd;
    w_gnt_nxt    = r_gnt_id;
    w_rdata0_nxt = r_rdata0;
    w_rdata1_nxt = r_rdata1;
    w_sel_nxt    = (w_state_nxt == STROBE);
    w_busy_nxt   = (w_state_nxt != IDLE);
    w_ack0_nxt   = (w_state_nxt == RECOVER) && !r_gnt_id;
    w_ack1_nxt   = (w_state_nxt == RECOVER) &&  r_gnt_id;
    if (w_grant) begin
      w_cmd_nxt = w_win_cmd;
      w_gnt_nxt = w_win;
    end
    // Read data is sampled at the edge closing the last strobe cycle
    if ((r_state == STROBE) && w_last && !r_cmd.we) begin
      if (r_gnt_id) w_rdata1_nxt = bus.ram_outp;
      else          w_rdata0_nxt = bus.ram_outp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd    <= '0;
      r_gnt_id <= 1'b0;
      r_sel    <= 1'b0;
      r_busy   <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_cmd    <= w_cmd_nxt;
      r_gnt_id <= w_gnt_nxt;
      r_sel    <= w_sel_nxt;
      r_busy   <= w_busy_nxt;
      r_ack0   <= w_ack0_nxt;
      r_ack1   <= w_ack1_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
    end
  end

  // Strobe-length counter, only advances inside STROBE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (r_state != STROBE) r_cnt <= '0;
    else if (w_last)            r_cnt <= '0;
    else                        r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.ram_addr = r_cmd.addr;
  assign bus.ram_inp  = r_cmd.wdata;
  assign bus.ram_op   = r_cmd.we;
  assign bus.ram_sel  = r_sel;
  assign bus.busy     = r_busy;
  assign bus.gnt_id   = r_gnt_id;
  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Directed bench for ram_arb_ctrl: one instance with 1 strobe cycle, one with 3,
// each attached to a behavioural 8x8 RAM.
module tb_ram_arb_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ram_arb_ctrl_if b1 ();
  ram_arb_ctrl_if b3 ();

  ram_arb_ctrl #(.STROBE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ram_arb_ctrl #(.STROBE_CYCLES(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  // Behavioural RAMs: write on a clock edge while sel&op, asynchronous read
  logic [7:0] mem1 [8];
  logic [7:0] mem3 [8];
  always @(posedge clk) if (b1.ram_sel && b1.ram_op) mem1[b1.ram_addr] <= b1.ram_inp;
  always @(posedge clk) if (b3.ram_sel && b3.ram_op) mem3[b3.ram_addr] <= b3.ram_inp;
  assign b1.ram_outp = mem1[b1.ram_addr];
  assign b3.ram_outp = mem3[b3.ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ack of port p on dut d; checks the negedge count, then drops req.
  task automatic wait_ack(input bit d, input bit p, input int exp_cyc, input string tag);
    int   found;
    logic a;
    found = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      a = d ? (p ? b3.ack1 : b3.ack0) : (p ? b1.ack1 : b1.ack0);
      if (a) begin
        found = c;
        break;
      end
    end
    chk(tag, 32'(found), 32'(exp_cyc));
    if (d) begin
      if (p) b3.req1 = 1'b0; else b3.req0 = 1'b0;
    end else begin
      if (p) b1.req1 = 1'b0; else b1.req0 = 1'b0;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pins"}, {b1.ram_sel, b1.ram_op, b1.ram_addr, b1.ram_inp}, 32'h0);
    chk({tag, "_stat"}, {b1.ack0, b1.ack1, b1.busy, b1.gnt_id}, 32'h0);
    chk({tag, "_rdata"}, {b1.rdata0, b1.rdata1}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [5:0] sel_pat;
  logic [5:0] ack_pat;

  initial begin
    rst_n = 1'b0;
    {b1.req0, b1.we0, b1.addr0, b1.wdata0, b1.req1, b1.we1, b1.addr1, b1.wdata1} = '0;
    {b3.req0, b3.we0, b3.addr0, b3.wdata0, b3.req1, b3.we1, b3.addr1, b3.wdata1} = '0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    chk("reset_dut3_sel_busy", {b3.ram_sel, b3.busy}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Port 0 writes AA to addr 1
    b1.req0 = 1'b1; b1.we0 = 1'b1; b1.addr0 = 3'd1; b1.wdata0 = 8'hAA;
    @(negedge clk);
    chk("wr_setup_pins", {b1.ram_sel, b1.ram_op, b1.ram_addr, b1.ram_inp}, {1'b0, 1'b1, 3'd1, 8'hAA});
    chk("wr_setup_busy_ack", {b1.busy, b1.ack0}, 32'b10);
    @(negedge clk);
    chk("wr_strobe", {b1.ram_sel, b1.ram_op, b1.ram_addr, b1.ack0}, {1'b1, 1'b1, 3'd1, 1'b0});
    @(negedge clk);
    chk("wr_recover", {b1.ram_sel, b1.ack0, b1.ack1, b1.gnt_id, b1.busy}, 32'b01001);
    b1.req0 = 1'b0;
    @(negedge clk);
    chk("wr_idle", {b1.busy, b1.ack0, b1.ram_sel, b1.ram_addr, b1.ram_op}, {1'b0, 1'b0, 1'b0, 3'd1, 1'b1});

    // Port 1 reads addr 1
    b1.req1 = 1'b1; b1.we1 = 1'b0; b1.addr1 = 3'd1;
    @(negedge clk);
    chk("rd_setup", {b1.ram_sel, b1.ram_op, b1.ram_addr, b1.gnt_id}, {1'b0, 1'b0, 3'd1, 1'b1});
    @(negedge clk);
    chk("rd_strobe", {b1.ram_sel, b1.ram_op, b1.ack1}, 32'b100);
    @(negedge clk);
    chk("rd_ack1", {b1.ack1, b1.ack0, b1.ram_sel}, 32'b100);
    chk("rd_rdata1", b1.rdata1, 32'hAA);
    chk("rd_rdata0_untouched", b1.rdata0, 32'h00);
    b1.req1 = 1'b0;
    @(negedge clk);

    // Simultaneous writes: port 0 preferred in both arbitration modes here
    b1.req0 = 1'b1; b1.we0 = 1'b1; b1.addr0 = 3'd2; b1.wdata0 = 8'h11;
    b1.req1 = 1'b1; b1.we1 = 1'b1; b1.addr1 = 3'd3; b1.wdata1 = 8'h22;
    wait_ack(1'b0, 1'b0, 3, "both_ack0_first");
    chk("both_no_ack1_yet", b1.ack1, 32'h0);
    wait_ack(1'b0, 1'b1, 4, "both_ack1_second");
    @(negedge clk);

    // Port 0 reads addr 3 (port 1's write)
    b1.req0 = 1'b1; b1.we0 = 1'b0; b1.addr0 = 3'd3;
    wait_ack(1'b0, 1'b0, 3, "rd3_ack0");
    chk("rd3_rdata0", b1.rdata0, 32'h22);
    chk("rd3_rdata1_untouched", b1.rdata1, 32'hAA);
    @(negedge clk);

    // Simultaneous reads of addr 2 after a lone port-0 grant
    b1.req0 = 1'b1; b1.we0 = 1'b0; b1.addr0 = 3'd2;
    b1.req1 = 1'b1; b1.we1 = 1'b0; b1.addr1 = 3'd2;
    @(negedge clk);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    chk("tie_winner_rr", b1.gnt_id, 32'h1);
    wait_ack(1'b0, 1'b1, 2, "tie_rr_ack1_first");
    wait_ack(1'b0, 1'b0, 4, "tie_rr_ack0_second");
`else
    chk("tie_winner_fixed", b1.gnt_id, 32'h0);
    wait_ack(1'b0, 1'b0, 2, "tie_fixed_ack0_first");
    wait_ack(1'b0, 1'b1, 4, "tie_fixed_ack1_after_req0_drop");
`endif
    chk("tie_rdata", {b1.rdata0, b1.rdata1}, 32'h1111);
    @(negedge clk);

    // 3-cycle strobe instance: write 11 to addr 2, then read it back
    b3.req0 = 1'b1; b3.we0 = 1'b1; b3.addr0 = 3'd2; b3.wdata0 = 8'h11;
    wait_ack(1'b1, 1'b0, 5, "s3_wr_ack0");
    @(negedge clk);
    sel_pat = 6'b001110;
    ack_pat = 6'b010000;
    b3.req0 = 1'b1; b3.we0 = 1'b0; b3.addr0 = 3'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("s3_rd_sel_c%0d", i + 1), b3.ram_sel, 32'(sel_pat[i]));
      chk($sformatf("s3_rd_ack_c%0d", i + 1), b3.ack0, 32'(ack_pat[i]));
      chk($sformatf("s3_rd_addr_c%0d", i + 1), b3.ram_addr, 32'd2);
      if (i == 1) begin
        b3.addr0 = 3'd5; b3.wdata0 = 8'hFF;
      end
      if (i == 4) begin
        chk("s3_rd_rdata0", b3.rdata0, 32'h11);
        b3.req0 = 1'b0;
      end
    end

    // Reset in the middle of a write strobe on the 1-cycle instance
    b1.req0 = 1'b1; b1.we0 = 1'b1; b1.addr0 = 3'd1; b1.wdata0 = 8'h77;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_sel", b1.ram_sel, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    b1.req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_ack", {b1.ack0, b1.ack1, b1.busy}, 32'h0);
    end
    b1.req1 = 1'b1; b1.we1 = 1'b0; b1.addr1 = 3'd1;
    wait_ack(1'b0, 1'b1, 3, "rst_rd_ack1");
    chk("rst_rd_old_value", b1.rdata1, 32'hAA);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_arb_ctrl.md
Name: ram_arb_ctrl

Overview:
- Clocked controller that shares the 8x8 byte RAM (8-bit inp/outp, 3-bit addr, op 1=write / 0=read, sel strobe) between two requesters.
- Arbitrates between the requesters and latches the winning command.
- Sequences the RAM pins setup -> strobe -> recover so addr, inp and op are stable whenever sel is high.
- Returns read data and a one-cycle acknowledge to the granted port.

Parameters:
- STROBE_CYCLES, 1, number of cycles ram_sel is held high per access; legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0 op, 1=write, 0=read.
- addr0  input  3  port 0 byte address.
- wdata0  input  8  port 0 write data.
- ack0  output  1  port 0 access complete, one-cycle pulse.
- rdata0  output  8  port 0 read data register.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- busy  output  1  an access is in progress (state != IDLE).
- gnt_id  output  1  port owning the current or last access.
- ram_inp  output  8  to RAM inp.
- ram_addr  output  3  to RAM addr.
- ram_op  output  1  to RAM op.
- ram_sel  output  1  to RAM sel.
- ram_outp  input  8  from RAM outp.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0: ram_sel, ram_op, ram_addr, ram_inp, ack0/1, rdata0/1, busy, gnt_id.
  - Round-robin pointer = port 0 preferred, strobe counter = 0.
- Reset asserted mid-access:
  - ram_sel drops to 0 immediately and the access is abandoned with no ack.
  - RAM contents are not reset.
- States: IDLE, SETUP, STROBE, RECOVER.
- IDLE:
  - If any req is high at a rising edge, select a winner and latch its we/addr/wdata into the command register.
  - Set gnt_id to the winner and go to SETUP.
  - If no req is high, stay in IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the preferred port wins. After every grant the pointer switches to prefer the other port.
- SETUP (1 cycle): ram_addr, ram_inp and ram_op driven from the command register; ram_sel=0.
- STROBE (STROBE_CYCLES cycles):
  - ram_sel=1; ram_addr, ram_inp and ram_op unchanged.
  - A counter counts from 0 to STROBE_CYCLES-1.
  - On a read, ram_outp is captured into rdata of the granted port at the edge that ends the last STROBE cycle.
- RECOVER (1 cycle):
  - ram_sel=0; ram_addr, ram_op and ram_inp still held.
  - ack of the granted port = 1; the other ack = 0.
  - Next state: IDLE.
- Latency: if req is sampled at edge E0, ack is high during cycle STROBE_CYCLES+2 after E0. With the default this is 3 cycles. An idle-to-idle access takes STROBE_CYCLES+3 cycles.
- busy=1 in SETUP, STROBE and RECOVER.
- Outside STROBE, ram_addr, ram_op and ram_inp hold their last values; they change only on entry to SETUP.
- Requester changes to we/addr/wdata after the grant are ignored; the latched command is used.
- Requester deasserts req on the edge where it samples ack high. A req still high in IDLE counts as a new request.
- rdata of a port changes only on that port's reads. Writes and the other port's accesses leave it unchanged.
- A write to port 0's rdata address by port 1 does not update rdata0.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, port 0 always wins simultaneous requests. The pointer logic is removed and port 1 is served only when req0=0 in IDLE.

Test Plan:
- Reset then port 0 write 8'hAA to addr 1 -> ram_op=1 and ram_addr=1 from SETUP; ram_sel high exactly 1 cycle; ack0 in the 3rd cycle after sampling; busy low afterwards.
- Port 1 read addr 1 after that write -> ram_sel high 1 cycle with ram_op=0; rdata1=8'hAA when ack1 pulses; rdata0 unchanged (0).
- Both req high in IDLE, port 0 write 8'h11 to addr 2, port 1 write 8'h22 to addr 3:
  - With RAM_ARB_ROUND_ROBIN_EN: port 0 served, then port 1; ack0 then ack1.
  - Without the macro: port 0 served, and port 1 is served only after req0 drops.
- STROBE_CYCLES=3, port 0 reads addr 2 -> ram_sel high exactly 3 consecutive cycles; ack0 5 cycles after sampling; rdata0=8'h11.
- Port 0 changes addr0 from 2 to 5 during STROBE -> ram_addr stays 2 until the next SETUP.
- rst_n pulled low during STROBE of a write -> ram_sel=0 immediately, no ack, all outputs 0, state IDLE; a subsequent read of that address returns the pre-access value if sel had not yet been high.
